// File: rtl/matmul_tile_scheduler_if.sv
// Control/status bundle between the start logic, the tile scheduler and the MAC array.
// The master drives requests, config and flow control; the slave (scheduler) drives addresses and accumulator controls.
interface matmul_tile_scheduler_if #(
    parameter int CORE_COUNT = 4,
    parameter int ADR_W      = 5
);
    logic                  start;
    logic [ADR_W-1:0]      cfg_rows;
    logic [ADR_W-1:0]      cfg_cols;
    logic [ADR_W-1:0]      cfg_inner;
    logic                  i_stall;
    logic                  i_wb_ready;
    logic [ADR_W-1:0]      o_row_adr;
    logic [ADR_W-1:0]      o_k_adr;
    logic [ADR_W-1:0]      o_col_base;
    logic [CORE_COUNT-1:0] o_core_mask;
    logic                  o_acc_clr;
    logic                  o_acc_en;
    logic                  o_acc_last;
    logic                  o_wb_valid;
    logic                  o_busy;
    logic                  o_done;
    logic [2:0]            o_state;

    modport master (
        output start, cfg_rows, cfg_cols, cfg_inner, i_stall, i_wb_ready,
        input  o_row_adr, o_k_adr, o_col_base, o_core_mask, o_acc_clr, o_acc_en,
               o_acc_last, o_wb_valid, o_busy, o_done, o_state
    );

    modport slave (
        input  start, cfg_rows, cfg_cols, cfg_inner, i_stall, i_wb_ready,
        output o_row_adr, o_k_adr, o_col_base, o_core_mask, o_acc_clr, o_acc_en,
               o_acc_last, o_wb_valid, o_busy, o_done, o_state
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks C = A * B one CORE_COUNT-wide column group at a time, streaming inner-dimension
// addresses with accumulator controls and handing each finished row to write-back.
module matmul_tile_scheduler #(
    parameter int CORE_COUNT = 4,
    parameter int ADR_W      = 5
) (
    input logic                     CLOCK_25,
    input logic                     rst,
    matmul_tile_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_WB     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADR_W-1:0] ONE     = ADR_W'(1);
    localparam logic [ADR_W:0]   GROUP_W = (ADR_W+1)'(CORE_COUNT);

    state_t           state_q, state_d;
    logic [ADR_W-1:0] row_q, row_d;
    logic [ADR_W-1:0] k_q, k_d;
    logic [ADR_W-1:0] col_q, col_d;
    logic [ADR_W-1:0] rows_q, rows_d;
    logic [ADR_W-1:0] cols_q, cols_d;
    logic [ADR_W-1:0] inner_q, inner_d;

    logic                  acc_en;
    logic                  acc_clr;
    logic                  acc_last;
    logic                  wb_valid;
    logic [CORE_COUNT-1:0] core_mask;
    logic [ADR_W:0]        col_next;

    always_ff @(posedge CLOCK_25 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            k_q     <= '0;
            col_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            inner_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            k_q     <= k_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            inner_q <= inner_d;
        end
    end

    // Group advance is evaluated one bit wider so cols near 2^ADR_W cannot wrap.
    assign col_next = {1'b0, col_q} + GROUP_W;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        k_d       = k_q;
        col_d     = col_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        inner_d   = inner_q;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        acc_last  = 1'b0;
        wb_valid  = 1'b0;
        core_mask = '0;

        unique case (state_q)
            S_IDLE: begin
                row_d = '0;
                k_d   = '0;
                col_d = '0;
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                rows_d  = bus.cfg_rows;
                cols_d  = bus.cfg_cols;
                inner_d = bus.cfg_inner;
                row_d   = '0;
                k_d     = '0;
                col_d   = '0;
                if (bus.cfg_rows == '0 || bus.cfg_cols == '0 || bus.cfg_inner == '0)
                    state_d = S_DONE;
                else
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                acc_en   = !bus.i_stall;
                acc_clr  = acc_en && (k_q == '0);
                acc_last = acc_en && (k_q == inner_q - ONE);
                if (!bus.i_stall) begin
                    if (k_q == inner_q - ONE) begin
                        k_d     = '0;
                        state_d = S_WB;
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (bus.i_wb_ready) begin
                    if (row_q < rows_q - ONE) begin
                        row_d   = row_q + ONE;
                        state_d = S_STREAM;
                    end else if (col_next < {1'b0, cols_q}) begin
                        row_d   = '0;
                        col_d   = col_next[ADR_W-1:0];
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_STREAM || state_q == S_WB) begin
            for (int i = 0; i < CORE_COUNT; i++)
                core_mask[i] = ({1'b0, col_q} + (ADR_W+1)'(i)) < {1'b0, cols_q};
        end
    end

    assign bus.o_row_adr   = row_q;
    assign bus.o_k_adr     = k_q;
    assign bus.o_col_base  = col_q;
    assign bus.o_core_mask = core_mask;
    assign bus.o_acc_clr   = acc_clr;
    assign bus.o_acc_en    = acc_en;
    assign bus.o_acc_last  = acc_last;
    assign bus.o_wb_valid  = wb_valid;
    assign bus.o_busy      = (state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_WB);
    assign bus.o_done      = (state_q == S_DONE);
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: cycle-by-cycle state/address/control traces
// against hand-written expectation tables.
module tb_matmul_tile_scheduler;

    localparam int CC = 4;
    localparam int AW = 5;

    logic CLOCK_25 = 1'b0;
    logic rst      = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    matmul_tile_scheduler_if #(.CORE_COUNT(CC), .ADR_W(AW)) bus ();

    matmul_tile_scheduler #(.CORE_COUNT(CC), .ADR_W(AW)) dut (
        .CLOCK_25 (CLOCK_25),
        .rst      (rst),
        .bus      (bus)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    // Expected {acc_en, acc_clr, acc_last, wb_valid, busy, done} for a given state/k.
    function automatic logic [5:0] exp_ctrl(input int st, input int k, input int inner, input logic stall);
        logic en;
        en = (st == 2) && !stall;
        return {en, en && (k == 0), en && (k == inner - 1), st == 3,
                (st >= 1 && st <= 3), st == 4};
    endfunction

    function automatic logic [5:0] act_ctrl();
        return {bus.o_acc_en, bus.o_acc_clr, bus.o_acc_last, bus.o_wb_valid, bus.o_busy, bus.o_done};
    endfunction

    function automatic logic [38:0] all_outs();
        return {bus.o_state, bus.o_row_adr, bus.o_k_adr, bus.o_col_base, bus.o_core_mask,
                bus.o_acc_clr, bus.o_acc_en, bus.o_acc_last, bus.o_wb_valid, bus.o_busy, bus.o_done,
                13'd0};
    endfunction

    task automatic test_reset();
        bus.start = 1'b1; bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd3;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge CLOCK_25);
        #1;
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp 0", all_outs());
        end
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle state got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_basic();
        int exp_st[10]  = '{1,2,2,2,3,2,2,2,3,4};
        int exp_k[10]   = '{0,0,1,2,0,0,1,2,0,0};
        int exp_row[10] = '{0,0,0,0,0,1,1,1,1,1};
        int n_en = 0, n_clr = 0, n_last = 0, n_wb = 0;
        logic [3:0] em;
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd3;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK_25); #1;
            em = (exp_st[c] == 2 || exp_st[c] == 3) ? 4'b1111 : 4'b0000;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c])) begin
                n_fail++; $display("FAIL basic_state c=%0d got %0d exp %0d", c, bus.o_state, exp_st[c]);
            end
            n_tests++;
            if (bus.o_k_adr !== 5'(exp_k[c]) || bus.o_row_adr !== 5'(exp_row[c]) || bus.o_col_base !== 5'd0) begin
                n_fail++; $display("FAIL basic_addr c=%0d got r%0d k%0d col%0d exp r%0d k%0d col0",
                                   c, bus.o_row_adr, bus.o_k_adr, bus.o_col_base, exp_row[c], exp_k[c]);
            end
            n_tests++;
            if (bus.o_core_mask !== em || act_ctrl() !== exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0)) begin
                n_fail++; $display("FAIL basic_ctrl c=%0d got mask %b ctrl %b exp mask %b ctrl %b",
                                   c, bus.o_core_mask, act_ctrl(), em, exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0));
            end
            n_en += int'(bus.o_acc_en); n_clr += int'(bus.o_acc_clr);
            n_last += int'(bus.o_acc_last); n_wb += int'(bus.o_wb_valid);
        end
        n_tests++;
        if (n_en != 6 || n_clr != 2 || n_last != 2 || n_wb != 2) begin
            n_fail++; $display("FAIL basic_counts got en%0d clr%0d last%0d wb%0d exp en6 clr2 last2 wb2",
                               n_en, n_clr, n_last, n_wb);
        end
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_done !== 1'b1) begin
            n_fail++; $display("FAIL basic_done_hold got %b exp 1", bus.o_done);
        end
        bus.start = 1'b0;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL basic_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_col_groups();
        int         exp_st[8]   = '{1,2,2,3,2,2,3,4};
        int         exp_k[8]    = '{0,0,1,0,0,1,0,0};
        int         exp_col[8]  = '{0,0,0,0,4,4,4,4};
        logic [3:0] exp_mask[8] = '{4'b0000,4'b1111,4'b1111,4'b1111,4'b0011,4'b0011,4'b0011,4'b0000};
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd1; bus.cfg_cols = 5'd6; bus.cfg_inner = 5'd2;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLOCK_25); #1;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c]) || bus.o_k_adr !== 5'(exp_k[c]) || bus.o_row_adr !== 5'd0) begin
                n_fail++; $display("FAIL group_state c=%0d got st%0d k%0d r%0d exp st%0d k%0d r0",
                                   c, bus.o_state, bus.o_k_adr, bus.o_row_adr, exp_st[c], exp_k[c]);
            end
            n_tests++;
            if (bus.o_col_base !== 5'(exp_col[c]) || bus.o_core_mask !== exp_mask[c]) begin
                n_fail++; $display("FAIL group_col c=%0d got col%0d mask %b exp col%0d mask %b",
                                   c, bus.o_col_base, bus.o_core_mask, exp_col[c], exp_mask[c]);
            end
            n_tests++;
            if (act_ctrl() !== exp_ctrl(exp_st[c], exp_k[c], 2, 1'b0)) begin
                n_fail++; $display("FAIL group_ctrl c=%0d got %b exp %b", c, act_ctrl(), exp_ctrl(exp_st[c], exp_k[c], 2, 1'b0));
            end
        end
        bus.start = 1'b0;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL group_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_stall();
        int exp_st[12]  = '{1,2,2,2,2,2,3,2,2,2,3,4};
        int exp_k[12]   = '{0,0,1,1,1,2,0,0,1,2,0,0};
        int exp_row[12] = '{0,0,0,0,0,0,0,1,1,1,1,1};
        int n_en = 0, n_clr = 0;
        logic stall;
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd3;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLOCK_25);
            stall = (c == 2 || c == 3);
            bus.i_stall = stall;
            #1;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c]) || bus.o_k_adr !== 5'(exp_k[c]) || bus.o_row_adr !== 5'(exp_row[c])) begin
                n_fail++; $display("FAIL stall_trace c=%0d got st%0d k%0d r%0d exp st%0d k%0d r%0d",
                                   c, bus.o_state, bus.o_k_adr, bus.o_row_adr, exp_st[c], exp_k[c], exp_row[c]);
            end
            n_tests++;
            if (act_ctrl() !== exp_ctrl(exp_st[c], exp_k[c], 3, stall)) begin
                n_fail++; $display("FAIL stall_ctrl c=%0d got %b exp %b", c, act_ctrl(), exp_ctrl(exp_st[c], exp_k[c], 3, stall));
            end
            n_en += int'(bus.o_acc_en); n_clr += int'(bus.o_acc_clr);
        end
        bus.i_stall = 1'b0;
        n_tests++;
        if (n_en != 6 || n_clr != 2) begin
            n_fail++; $display("FAIL stall_counts got en%0d clr%0d exp en6 clr2", n_en, n_clr);
        end
        bus.start = 1'b0;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL stall_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_backpressure();
        int exp_st[13]  = '{1,2,2,2,3,3,3,3,2,2,2,3,4};
        int exp_k[13]   = '{0,0,1,2,0,0,0,0,0,1,2,0,0};
        int exp_row[13] = '{0,0,0,0,0,0,0,0,1,1,1,1,1};
        int n_wb = 0;
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd3;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge CLOCK_25);
            bus.i_wb_ready = !(c >= 4 && c <= 6);
            if (c == 2) bus.cfg_inner = 5'd7;
            #1;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c]) || bus.o_k_adr !== 5'(exp_k[c]) ||
                bus.o_row_adr !== 5'(exp_row[c]) || bus.o_col_base !== 5'd0) begin
                n_fail++; $display("FAIL bp_trace c=%0d got st%0d k%0d r%0d col%0d exp st%0d k%0d r%0d col0",
                                   c, bus.o_state, bus.o_k_adr, bus.o_row_adr, bus.o_col_base,
                                   exp_st[c], exp_k[c], exp_row[c]);
            end
            n_tests++;
            if (act_ctrl() !== exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0)) begin
                n_fail++; $display("FAIL bp_ctrl c=%0d got %b exp %b", c, act_ctrl(), exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0));
            end
            n_wb += int'(bus.o_wb_valid);
        end
        n_tests++;
        if (n_wb != 5) begin
            n_fail++; $display("FAIL bp_wb_cycles got %0d exp 5", n_wb);
        end
        bus.start = 1'b0; bus.cfg_inner = 5'd3;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL bp_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_zero_cfg();
        int exp_st[3] = '{1,4,4};
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd0;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLOCK_25); #1;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c]) || act_ctrl() !== exp_ctrl(exp_st[c], 0, 0, 1'b0)) begin
                n_fail++; $display("FAIL zero_cfg c=%0d got st%0d ctrl %b exp st%0d ctrl %b",
                                   c, bus.o_state, act_ctrl(), exp_st[c], exp_ctrl(exp_st[c], 0, 0, 1'b0));
            end
        end
        bus.start = 1'b0;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL zero_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    task automatic test_reset_midrun();
        int exp_st[10]  = '{1,2,2,2,3,2,2,2,3,4};
        int exp_k[10]   = '{0,0,1,2,0,0,1,2,0,0};
        int exp_row[10] = '{0,0,0,0,0,1,1,1,1,1};
        @(negedge CLOCK_25);
        bus.cfg_rows = 5'd2; bus.cfg_cols = 5'd4; bus.cfg_inner = 5'd3;
        bus.i_stall = 1'b0; bus.i_wb_ready = 1'b1; bus.start = 1'b1;
        repeat (6) @(negedge CLOCK_25);
        #1;
        n_tests++;
        if (bus.o_state !== 3'd2 || bus.o_row_adr !== 5'd1 || bus.o_acc_en !== 1'b1) begin
            n_fail++; $display("FAIL midrun_setup got st%0d r%0d en%b exp st2 r1 en1",
                               bus.o_state, bus.o_row_adr, bus.o_acc_en);
        end
        #5 rst = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL midrun_async_reset got %h exp 0", all_outs());
        end
        @(negedge CLOCK_25);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK_25); #1;
            n_tests++;
            if (bus.o_state !== 3'(exp_st[c]) || bus.o_k_adr !== 5'(exp_k[c]) ||
                bus.o_row_adr !== 5'(exp_row[c]) || bus.o_col_base !== 5'd0 ||
                act_ctrl() !== exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0)) begin
                n_fail++; $display("FAIL restart_trace c=%0d got st%0d k%0d r%0d ctrl %b exp st%0d k%0d r%0d ctrl %b",
                                   c, bus.o_state, bus.o_k_adr, bus.o_row_adr, act_ctrl(),
                                   exp_st[c], exp_k[c], exp_row[c], exp_ctrl(exp_st[c], exp_k[c], 3, 1'b0));
            end
        end
        bus.start = 1'b0;
        @(negedge CLOCK_25); #1;
        n_tests++;
        if (bus.o_state !== 3'd0) begin
            n_fail++; $display("FAIL restart_return_idle got %0d exp 0", bus.o_state);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_col_groups();
        test_stall();
        test_backpressure();
        test_zero_cfg();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
Sequencer for the CORE_COUNT-wide MAC core array. It walks C[rows x cols] = A[rows x inner] * B[inner x cols] one column group at a time, where a column group is CORE_COUNT adjacent columns. For each row it streams inner-dimension addresses with accumulator controls, then hands the result to write-back with a valid/ready handshake. It sits between the top-level start control and the core array and operand memories, and supersedes free-running scan counters with explicit stall and back-pressure support.

Parameters:
CORE_COUNT, 4, number of MAC cores; columns processed per group.
ADR_W, 5, width of row, column and inner-dimension address and config fields.

Ports:
CLOCK_25  in  1  system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  level request; run begins when high in IDLE; DONE is held until it drops.
cfg_rows  in  ADR_W  row count of A/C; latched in LOAD.
cfg_cols  in  ADR_W  column count of B/C; latched in LOAD.
cfg_inner  in  ADR_W  inner dimension; latched in LOAD.
i_stall  in  1  operand not available; freezes streaming for this cycle.
i_wb_ready  in  1  write-back accepts the current row result.
o_row_adr  out  ADR_W  current row r.
o_k_adr  out  ADR_W  current inner index k.
o_col_base  out  ADR_W  first column of the current group.
o_core_mask  out  CORE_COUNT  bit i = core i is computing a valid column.
o_acc_clr  out  1  clear accumulators before this MAC.
o_acc_en  out  1  cores perform a MAC this cycle.
o_acc_last  out  1  final MAC of the row.
o_wb_valid  out  1  row result ready for write-back.
o_busy  out  1  state is LOAD, STREAM or WB.
o_done  out  1  state is DONE.
o_state  out  3  IDLE=0, LOAD=1, STREAM=2, WB=3, DONE=4.

Behaviour:
- Reset (async, rst=0): state=IDLE. All counters and latched config are 0. All outputs are 0.
- IDLE: counters are held at 0. If start=1, go to LOAD on the next edge.
- LOAD (1 cycle): latch the three cfg_* inputs. If any latched value is 0, go to DONE. Otherwise set row=k=col_base=0 and go to STREAM.
- STREAM, decoded combinationally from the registered state:
  - o_acc_en = !i_stall.
  - o_acc_clr = o_acc_en && k==0.
  - o_acc_last = o_acc_en && k==inner-1.
- STREAM, sequential:
  - If i_stall=1: k is frozen and the state is unchanged.
  - Else if k==inner-1: k<=0, go to WB.
  - Else: k<=k+1.
- WB: o_wb_valid=1. The state holds until i_wb_ready=1. On acceptance:
  - If row<rows-1: row<=row+1, go to STREAM.
  - Else if col_base+CORE_COUNT<cols: row<=0, col_base<=col_base+CORE_COUNT, go to STREAM.
  - Else: go to DONE.
- DONE: o_done=1. Go to IDLE when start=0.
- Arithmetic:
  - col_base+CORE_COUNT is computed at ADR_W+1 bits, so there is no wrap at cols near 2^ADR_W.
  - o_core_mask[i] = (col_base+i < cols) at ADR_W+1 bits, whenever state is STREAM or WB; 0 otherwise.
- start is ignored outside IDLE and DONE. Dropping start mid-run does not abort the run.
- A cfg_* change after LOAD has no effect.
- i_stall is don't-care outside STREAM. i_wb_ready is don't-care outside WB.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0. There is no pending write-back after reset.
- Latency: start sampled high at edge N puts the block in LOAD after N and in STREAM after N+1, with the first o_acc_en in that cycle.
- Unstalled, with i_wb_ready tied high, one row costs inner+1 cycles.

Test Plan:
1. CORE_COUNT=4; rows=2, cols=4, inner=3; no stall; wb_ready=1 -> acc_en high 6 cycles total. acc_clr at k=0 of each row, acc_last at k=2. 2 wb_valid pulses. mask=1111. DONE after 10 cycles from LOAD entry.
2. rows=1, cols=6, inner=2 -> col_base 0 with mask 1111, then col_base 4 with mask 0011. 2 write-backs, then DONE.
3. Case 1 with i_stall=1 for 2 cycles at k=1 of row 0 -> k holds at 1, acc_en=0 during the stall, total stream cycles +2, no duplicate acc_clr.
4. Case 1 with i_wb_ready low for 3 cycles at row 0 -> wb_valid held 4 cycles, row/k/col_base frozen. Row 1 streams after acceptance.
5. cfg_inner=0 -> IDLE, LOAD, DONE in 2 edges. acc_en and wb_valid never assert.
6. Assert rst during STREAM of row 1 -> state=IDLE and all outputs 0 immediately (asynchronous). Holding start=1 afterwards restarts from row 0, col_base 0.
